// File: rtl/datapath_seq_if.sv
// Command/status bundle between the controller and the self-sequencing datapath.
interface datapath_seq_if #(
    parameter int W  = 16,
    parameter int AW = 3
);
    logic          start;
    logic [1:0]    src_sel;
    logic [1:0]    alu_op;
    logic [1:0]    shift;
    logic          asel;
    logic          bsel;
    logic          wb_en;
    logic          flags_en;
    logic [AW-1:0] rd;
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic [7:0]    imm8;
    logic [4:0]    imm5;
    logic [W-1:0]  mdata;
    logic [AW-1:0] dbg_sel;
    logic          busy;
    logic          done;
    logic [W-1:0]  datapath_out;
    logic          V;
    logic          N;
    logic          Z;
    logic [W-1:0]  dbg_data;

    modport master (
        output start, src_sel, alu_op, shift, asel, bsel, wb_en, flags_en,
               rd, rn, rm, imm8, imm5, mdata, dbg_sel,
        input  busy, done, datapath_out, V, N, Z, dbg_data
    );

    modport slave (
        input  start, src_sel, alu_op, shift, asel, bsel, wb_en, flags_en,
               rd, rn, rm, imm8, imm5, mdata, dbg_sel,
        output busy, done, datapath_out, V, N, Z, dbg_data
    );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B/C pipeline registers, shifter,
// ALU and status register, driven by a start/busy/done command handshake.
// The interface instance connected to bus must use the same W/AW as this module.
module datapath_seq #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    datapath_seq_if.slave bus
);
    localparam int NREG = 2 ** AW;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOADA = 3'd1;
    localparam logic [2:0] LOADB = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;

    logic [2:0]    state;
    logic [W-1:0]  regs [NREG];
    logic [W-1:0]  a_reg, b_reg, c_reg;
    logic          v_flag, n_flag, z_flag;
    logic          done_reg;

    logic [1:0]    cmd_src, cmd_op, cmd_shift;
    logic          cmd_asel, cmd_bsel, cmd_wb, cmd_flags;
    logic [AW-1:0] cmd_rd, cmd_rn, cmd_rm;
    logic [7:0]    cmd_imm8;
    logic [4:0]    cmd_imm5;

    logic [W-1:0]  imm8_ext, imm5_ext, b_shift, ain, bin, alu_res, wb_value;
    logic          alu_v;

    assign imm8_ext = {{(W-8){cmd_imm8[7]}}, cmd_imm8};
    assign imm5_ext = {{(W-5){cmd_imm5[4]}}, cmd_imm5};
    assign ain      = cmd_asel ? '0 : a_reg;
    assign bin      = cmd_bsel ? imm5_ext : b_shift;

    // Shifter on the B pipeline register
    always_comb begin
        b_shift = b_reg;
        case (cmd_shift)
            2'b01:   b_shift = {b_reg[W-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_reg[W-1:1]};
            2'b11:   b_shift = {b_reg[W-1], b_reg[W-1:1]};
            default: b_shift = b_reg;
        endcase
    end

    // ALU result and signed-overflow detection
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (cmd_op)
            2'b00: begin
                alu_res = ain + bin;
                alu_v   = (ain[W-1] == bin[W-1]) && (alu_res[W-1] != ain[W-1]);
            end
            2'b01: begin
                alu_res = ain - bin;
                alu_v   = (ain[W-1] != bin[W-1]) && (alu_res[W-1] != ain[W-1]);
            end
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
    end

    // Write-back source selection; code 11 behaves like the ALU path
    always_comb begin
        wb_value = c_reg;
        case (cmd_src)
            2'b01:   wb_value = imm8_ext;
            2'b10:   wb_value = bus.mdata;
            default: wb_value = c_reg;
        endcase
    end

    // Sequencer, command latch, pipeline registers, status and done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            v_flag    <= 1'b0;
            n_flag    <= 1'b0;
            z_flag    <= 1'b0;
            done_reg  <= 1'b0;
            cmd_src   <= '0;
            cmd_op    <= '0;
            cmd_shift <= '0;
            cmd_asel  <= 1'b0;
            cmd_bsel  <= 1'b0;
            cmd_wb    <= 1'b0;
            cmd_flags <= 1'b0;
            cmd_rd    <= '0;
            cmd_rn    <= '0;
            cmd_rm    <= '0;
            cmd_imm8  <= '0;
            cmd_imm5  <= '0;
        end else begin
            done_reg <= (state == WB);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cmd_src   <= bus.src_sel;
                        cmd_op    <= bus.alu_op;
                        cmd_shift <= bus.shift;
                        cmd_asel  <= bus.asel;
                        cmd_bsel  <= bus.bsel;
                        cmd_wb    <= bus.wb_en;
                        cmd_flags <= bus.flags_en;
                        cmd_rd    <= bus.rd;
                        cmd_rn    <= bus.rn;
                        cmd_rm    <= bus.rm;
                        cmd_imm8  <= bus.imm8;
                        cmd_imm5  <= bus.imm5;
                        if (bus.src_sel == 2'b01 || bus.src_sel == 2'b10)
                            state <= WB;
                        else
                            state <= LOADA;
                    end
                end
                LOADA: begin
                    a_reg <= regs[cmd_rn];
                    state <= LOADB;
                end
                LOADB: begin
                    b_reg <= regs[cmd_rm];
                    state <= EXEC;
                end
                EXEC: begin
                    c_reg <= alu_res;
                    if (cmd_flags) begin
                        v_flag <= alu_v;
                        n_flag <= alu_res[W-1];
                        z_flag <= (alu_res == '0);
                    end
                    state <= WB;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register file, written only in the write-back state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (state == WB && cmd_wb) begin
            regs[cmd_rd] <= wb_value;
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_reg;
    assign bus.datapath_out = c_reg;
    assign bus.V            = v_flag;
    assign bus.N            = n_flag;
    assign bus.Z            = z_flag;
    assign bus.dbg_data     = regs[bus.dbg_sel];
endmodule

// File: tb/tb_datapath_seq.sv
// Directed self-checking bench for datapath_seq with hand-computed expectations.
module tb_datapath_seq;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   cycles;
    int   done_count;

    datapath_seq_if #(.W(16), .AW(3)) bus ();

    datapath_seq #(.W(16), .AW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkReg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        bus.dbg_sel = addr;
        #1;
        checkOutput(tag, {16'h0, bus.dbg_data}, {16'h0, exp});
    endtask

    task automatic checkFlags(input string tag, input logic [2:0] vnz);
        checkOutput(tag, {29'h0, bus.V, bus.N, bus.Z}, {29'h0, vnz});
    endtask

    task automatic setCmd(input logic [1:0] src, input logic [1:0] op, input logic [1:0] sh,
                          input logic as, input logic bs, input logic wb, input logic fl,
                          input logic [2:0] d, input logic [2:0] n, input logic [2:0] m,
                          input logic [7:0] i8, input logic [4:0] i5, input logic [15:0] md);
        bus.src_sel  = src;
        bus.alu_op   = op;
        bus.shift    = sh;
        bus.asel     = as;
        bus.bsel     = bs;
        bus.wb_en    = wb;
        bus.flags_en = fl;
        bus.rd       = d;
        bus.rn       = n;
        bus.rm       = m;
        bus.imm8     = i8;
        bus.imm5     = i5;
        bus.mdata    = md;
    endtask

    // Issue the prepared command, scramble the command inputs after accept,
    // then wait (bounded) for done and confirm it is a single-cycle pulse.
    task automatic applyStimulus(input string tag, output int busy_cycles);
        logic seen;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.src_sel  = ~bus.src_sel;
        bus.alu_op   = ~bus.alu_op;
        bus.shift    = ~bus.shift;
        bus.asel     = ~bus.asel;
        bus.bsel     = ~bus.bsel;
        bus.wb_en    = ~bus.wb_en;
        bus.flags_en = ~bus.flags_en;
        bus.rd       = ~bus.rd;
        bus.rn       = ~bus.rn;
        bus.rm       = ~bus.rm;
        bus.imm8     = ~bus.imm8;
        bus.imm5     = ~bus.imm5;
        seen         = 1'b0;
        busy_cycles  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done)
                seen = 1'b1;
            else if (bus.busy)
                busy_cycles++;
        end
        checkOutput({tag, "_done_seen"}, {31'h0, seen}, 32'd1);
        if (seen) begin
            checkOutput({tag, "_busy_at_done"}, {31'h0, bus.busy}, 32'd0);
            @(negedge clk);
            checkOutput({tag, "_done_pulse"}, {31'h0, bus.done}, 32'd0);
        end
    endtask

    task automatic movImm(input string tag, input logic [2:0] d, input logic [7:0] i8);
        setCmd(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, d, 3'd0, 3'd0, i8, 5'd0, 16'h0);
        applyStimulus(tag, cycles);
        checkOutput({tag, "_latency"}, cycles, 32'd1);
    endtask

    task automatic movMem(input string tag, input logic [2:0] d, input logic [15:0] md);
        setCmd(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, d, 3'd0, 3'd0, 8'h0, 5'd0, md);
        applyStimulus(tag, cycles);
        checkOutput({tag, "_latency"}, cycles, 32'd1);
    endtask

    task automatic aluCmd(input string tag, input logic [1:0] src, input logic [1:0] op,
                          input logic [1:0] sh, input logic as, input logic bs,
                          input logic wb, input logic fl, input logic [2:0] d,
                          input logic [2:0] n, input logic [2:0] m, input logic [4:0] i5);
        setCmd(src, op, sh, as, bs, wb, fl, d, n, m, 8'h0, i5, 16'h0);
        applyStimulus(tag, cycles);
        checkOutput({tag, "_latency"}, cycles, 32'd4);
    endtask

    // Directed scenario sequence
    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b1;
        bus.start   = 1'b0;
        bus.dbg_sel = 3'd0;
        setCmd(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h0, 5'd0, 16'h0);

        #2 reset_n = 1'b0;
        #1;
        $display("[TB] asynchronous reset checks");
        checkOutput("rst_busy", {31'h0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'h0, bus.done}, 32'd0);
        checkOutput("rst_dout", {16'h0, bus.datapath_out}, 32'h0);
        checkFlags("rst_flags", 3'b000);
        for (int i = 0; i < 8; i++)
            checkReg("rst_reg", i[2:0], 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] move immediate");
        movImm("mov_imm", 3'd2, 8'h85);
        checkReg("mov_r2", 3'd2, 16'hFF85);
        checkFlags("mov_flags", 3'b000);
        checkOutput("mov_c_held", {16'h0, bus.datapath_out}, 32'h0);

        $display("[TB] add with LSL1");
        movImm("set_r0", 3'd0, 8'h07);
        movImm("set_r1", 3'd1, 8'h02);
        aluCmd("add_lsl", 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0, 3'd1, 5'd0);
        checkReg("add_r3", 3'd3, 16'h000B);
        checkOutput("add_dout", {16'h0, bus.datapath_out}, 32'h000B);
        checkFlags("add_flags", 3'b000);

        $display("[TB] signed overflow");
        movMem("mem_r0", 3'd0, 16'h7FFF);
        checkReg("mem_r0_val", 3'd0, 16'h7FFF);
        movImm("set_r1b", 3'd1, 8'h01);
        aluCmd("ovf", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd0, 3'd1, 5'd0);
        checkReg("ovf_r4", 3'd4, 16'h8000);
        checkFlags("ovf_flags", 3'b110);

        $display("[TB] AND via source 11, NOT B");
        aluCmd("and11", 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 3'd0, 3'd4, 5'd0);
        checkReg("and_r6", 3'd6, 16'h0000);
        checkFlags("and_flags", 3'b001);
        aluCmd("notb", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 3'd1, 5'd0);
        checkReg("not_r7", 3'd7, 16'hFFFE);
        checkFlags("not_flags", 3'b010);

        $display("[TB] compare via SUB without write-back");
        movImm("set_r0c", 3'd0, 8'h05);
        checkFlags("mov_keeps_flags", 3'b010);
        movImm("set_r1c", 3'd1, 8'h05);
        aluCmd("cmp", 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 3'd1, 5'd0);
        checkFlags("cmp_flags", 3'b001);
        checkReg("cmp_r2_kept", 3'd2, 16'hFF85);
        checkOutput("cmp_dout", {16'h0, bus.datapath_out}, 32'h0);

        $display("[TB] immediate B operand and shifts");
        movMem("mem_r1", 3'd1, 16'h8004);
        aluCmd("bsel", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 3'd0, 3'd1, 5'h1F);
        checkReg("bsel_r3", 3'd3, 16'h0004);
        checkFlags("bsel_flags", 3'b000);
        aluCmd("lsr", 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 3'd1, 5'd0);
        checkReg("lsr_r6", 3'd6, 16'h4002);
        checkFlags("lsr_flags_kept", 3'b000);
        aluCmd("asr", 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 3'd0, 3'd1, 5'd0);
        checkReg("asr_r5", 3'd5, 16'hC002);
        checkFlags("asr_flags", 3'b010);

        $display("[TB] start during LOADB is ignored");
        setCmd(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 3'd0, 8'h0, 5'd0, 16'h0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ign_busy_loadb", {31'h0, bus.busy}, 32'd1);
        setCmd(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 8'h33, 5'd0, 16'h0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done)
                done_count++;
        end
        checkOutput("ign_one_done", done_count, 32'd1);
        checkReg("ign_r6", 3'd6, 16'h000A);
        checkReg("ign_r7_kept", 3'd7, 16'hFFFE);

        $display("[TB] reset during EXEC");
        @(negedge clk);
        setCmd(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd0, 3'd0, 8'h0, 5'd0, 16'h0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_busy_exec", {31'h0, bus.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_busy", {31'h0, bus.busy}, 32'd0);
        checkOutput("mid_dout", {16'h0, bus.datapath_out}, 32'h0);
        checkFlags("mid_flags", 3'b000);
        for (int i = 0; i < 8; i++)
            checkReg("mid_reg", i[2:0], 16'h0);
        done_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done)
                done_count++;
        end
        checkOutput("mid_no_done", done_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        movImm("post_rst", 3'd1, 8'h12);
        checkReg("post_r1", 3'd1, 16'h0012);
        checkReg("post_r4", 3'd4, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
